// File: rtl/lock_pkg.sv
// Shared types and constants for the lock controller and its input front end.
package lock_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    DB_IDLE       = 2'b00,
    DB_PRESS_PEND = 2'b01,
    DB_HELD       = 2'b10,
    DB_REL_PEND   = 2'b11
  } db_state_t;

  // Lock FSM encoding, owned here so the downstream controller shares it.
  localparam logic [2:0] LOCK_IDLE           = 3'b000;
  localparam logic [2:0] LOCK_SET_AWAITING   = 3'b001;
  localparam logic [2:0] LOCK_OPENED         = 3'b010;
  localparam logic [2:0] LOCK_ALARM          = 3'b011;
  localparam logic [2:0] LOCK_INPUT_PASSWORD = 3'b100;

endpackage

// File: rtl/debounce_cell.sv
// One push-button: two-flop synchronizer, debounce FSM with saturating counter,
// and single-cycle press-accept / release events.
module debounce_cell
  import lock_pkg::*;
#(
  parameter int DB_CYCLES = 1000
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      btn_raw,
  output logic      press_evt,
  output logic      release_evt,
  output logic      active,
  output db_state_t state_dbg
);

  localparam logic [CNT_W-1:0] TERM    = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic      btn_m, btn_s;
  db_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      state <= DB_IDLE;
      cnt   <= '0;
    end else begin
      btn_m <= btn_raw;
      btn_s <= btn_m;
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Each pending state counts DB_CYCLES cycles, including the cycle it is entered.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    press_evt   = 1'b0;
    release_evt = 1'b0;
    case (state)
      DB_IDLE: begin
        if (btn_s) begin
          state_nxt = DB_PRESS_PEND;
          cnt_nxt   = '0;
        end
      end
      DB_PRESS_PEND: begin
        if (!btn_s) begin
          state_nxt = DB_IDLE;
        end else if (cnt == TERM) begin
          state_nxt = DB_HELD;
          press_evt = 1'b1;
        end
      end
      DB_HELD: begin
        if (!btn_s) begin
          state_nxt = DB_REL_PEND;
          cnt_nxt   = '0;
        end
      end
      DB_REL_PEND: begin
        if (btn_s) begin
          state_nxt = DB_HELD;
        end else if (cnt == TERM) begin
          state_nxt   = DB_IDLE;
          release_evt = 1'b1;
        end
      end
      default: state_nxt = DB_IDLE;
    endcase
  end

  assign active    = (state == DB_HELD) || (state == DB_REL_PEND);
  assign state_dbg = state;

endmodule

// File: rtl/lock_input_conditioner.sv
// Lock front end: debounced set/check buttons, overlap (taint) arbitration and
// a code-switch snapshot delivered alongside every accepted pulse.
module lock_input_conditioner
  import lock_pkg::*;
#(
  parameter int DB_CYCLES = 1000,
  parameter int CODE_W    = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_btn_raw,
  input  logic              check_btn_raw,
  input  logic [CODE_W-1:0] code_raw,
  output logic              set_pulse,
  output logic              check_pulse,
  output logic [CODE_W-1:0] code_out,
  output logic              code_stale,
  output logic              conflict
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DB_CYCLES - 1);

  logic      set_press, set_rel, set_act;
  logic      chk_press, chk_rel, chk_act;
  db_state_t set_state, chk_state;

  debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_set (
    .clk, .rst_n, .btn_raw(set_btn_raw),
    .press_evt(set_press), .release_evt(set_rel), .active(set_act), .state_dbg(set_state)
  );

  debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_chk (
    .clk, .rst_n, .btn_raw(check_btn_raw),
    .press_evt(chk_press), .release_evt(chk_rel), .active(chk_act), .state_dbg(chk_state)
  );

  logic set_taint, chk_taint;
  logic overlap, set_taint_eff, chk_taint_eff;
  logic set_ok, chk_ok, conflict_nxt;

  // Fold in the current cycle's overlap so a release never misses it.
  assign overlap       = set_act && chk_act;
  assign set_taint_eff = set_taint || overlap;
  assign chk_taint_eff = chk_taint || overlap;
  assign set_ok        = set_rel && !set_taint_eff;
  assign chk_ok        = chk_rel && !chk_taint_eff;
  assign conflict_nxt  = (set_rel && set_taint_eff) || (chk_rel && chk_taint_eff);

  logic [CODE_W-1:0] code_m, code_s, code_d, stable_code;
  logic [CNT_W-1:0]  code_cnt;
  logic              code_same, code_is_stable;

  assign code_same      = (code_s == code_d);
  assign code_is_stable = code_same && (code_cnt == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_taint   <= 1'b0;
      chk_taint   <= 1'b0;
      code_m      <= '0;
      code_s      <= '0;
      code_d      <= '0;
      code_cnt    <= '0;
      stable_code <= '0;
      set_pulse   <= 1'b0;
      check_pulse <= 1'b0;
      conflict    <= 1'b0;
      code_out    <= '0;
      code_stale  <= 1'b0;
    end else begin
      if (set_press)    set_taint <= 1'b0;
      else if (overlap) set_taint <= 1'b1;
      if (chk_press)    chk_taint <= 1'b0;
      else if (overlap) chk_taint <= 1'b1;

      code_m <= code_raw;
      code_s <= code_m;
      code_d <= code_s;
      if (!code_same)            code_cnt <= '0;
      else if (code_cnt != TERM) code_cnt <= code_cnt + 1'b1;
      if (code_is_stable)        stable_code <= code_s;

      set_pulse   <= set_ok;
      check_pulse <= chk_ok;
      conflict    <= conflict_nxt;
      if (set_ok || chk_ok) begin
        code_out   <= stable_code;
        code_stale <= !code_is_stable;
      end
    end
  end

endmodule

// File: tb/tb_lock_input_conditioner.sv
// Directed bench for lock_input_conditioner with DB_CYCLES=4.
module tb_lock_input_conditioner;
  import lock_pkg::*;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       set_btn_raw = 1'b0;
  logic       check_btn_raw = 1'b0;
  logic [6:0] code_raw = 7'h00;
  logic       set_pulse, check_pulse, code_stale, conflict;
  logic [6:0] code_out;

  int checks = 0;
  int errors = 0;
  int n_set = 0, n_chk = 0, n_conf = 0;

  lock_input_conditioner #(.DB_CYCLES(DB), .CODE_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .set_btn_raw(set_btn_raw), .check_btn_raw(check_btn_raw),
    .code_raw(code_raw), .set_pulse(set_pulse), .check_pulse(check_pulse),
    .code_out(code_out), .code_stale(code_stale), .conflict(conflict)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      n_set  += int'(set_pulse);
      n_chk  += int'(check_pulse);
      n_conf += int'(conflict);
    end
  end

  // Inputs change and outputs are sampled 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    step(2);
    check("rst_set_pulse", 32'(set_pulse), 0);
    check("rst_code_out", 32'(code_out), 0);
    check("rst_stale_conf", {30'd0, code_stale, conflict}, 0);
    rst_n = 1'b1;
    code_raw = 7'h2A;
    step(10);

    // Clean set press, exact latency of the release pulse
    set_btn_raw = 1'b1;
    step(10);
    check("t1_held", 32'(dut.set_state), 32'(DB_HELD));
    set_btn_raw = 1'b0;
    step(6);
    check("t1_early", 32'(set_pulse), 0);
    step(1);
    check("t1_pulse", 32'(set_pulse), 1);
    check("t1_code", 32'(code_out), 32'h2A);
    check("t1_stale", 32'(code_stale), 0);
    step(1);
    check("t1_single", 32'(set_pulse), 0);
    step(5);
    check("t1_count", 32'(n_set), 1);

    // Bouncing check button, then a clean hold and release
    check_btn_raw = 1'b1; step(1);
    check_btn_raw = 1'b0; step(1);
    check_btn_raw = 1'b1; step(1);
    check_btn_raw = 1'b0; step(4);
    check("t2_bounce", 32'(n_chk), 0);
    check_btn_raw = 1'b1; step(10);
    check_btn_raw = 1'b0; step(12);
    check("t2_count", 32'(n_chk), 1);
    check("t2_code", 32'(code_out), 32'h2A);

    // Two-cycle glitch on set
    set_btn_raw = 1'b1; step(2);
    set_btn_raw = 1'b0; step(15);
    check("t3_no_pulse", 32'(n_set), 1);
    check("t3_idle", 32'(dut.set_state), 32'(DB_IDLE));

    // Overlapping presses: both releases become conflicts
    set_btn_raw = 1'b1; step(10);
    check_btn_raw = 1'b1; step(10);
    check_btn_raw = 1'b0; step(12);
    set_btn_raw = 1'b0; step(12);
    check("t4_conflicts", 32'(n_conf), 2);
    check("t4_pulses", 32'(n_set + n_chk), 2);
    check("t4_code", 32'(code_out), 32'h2A);

    // Code changes just before the check release completes
    code_raw = 7'h11; step(10);
    check_btn_raw = 1'b1; step(10);
    check_btn_raw = 1'b0; step(4);
    code_raw = 7'h12; step(3);
    check("t5_pulse", 32'(check_pulse), 1);
    check("t5_code", 32'(code_out), 32'h11);
    check("t5_stale", 32'(code_stale), 1);
    step(10);
    check("t5_count", 32'(n_chk), 2);

    // Reset during release debounce drops the event
    set_btn_raw = 1'b1; step(10);
    set_btn_raw = 1'b0; step(3);
    check("t6_rel_pend", 32'(dut.set_state), 32'(DB_REL_PEND));
    rst_n = 1'b0; step(2);
    check("t6_idle", 32'(dut.set_state), 32'(DB_IDLE));
    rst_n = 1'b1; step(15);
    check("t6_no_pulse", 32'(n_set), 1);
    check("t6_outputs", {21'd0, set_pulse, check_pulse, conflict, code_stale, code_out}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
